// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed seven-segment scanner with frame-aligned double buffering
//
// Purpose: scans NUM_DIGITS digits, one per SCAN_DIV clocks. Each slot opens
// with BLANK_CYCLES clocks of all selects inactive. New digit data is staged in
// a pending buffer and moved to the shadow (displayed) buffer only on the frame
// wrap, so a frame never mixes old and new values.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load                one-cycle strobe capturing data_in/en_in/dp_in
//   data_in[4N-1:0]     digit i hex value at [4i+3:4i]
//   en_in[N-1:0]        per-digit enable
//   dp_in[N-1:0]        per-digit decimal point
//   busy                pending buffer holds uncommitted data
//   seg[6:0]            segments a..g (polarity per SEG_ACTIVE_LOW)
//   dp                  decimal point (polarity per SEG_ACTIVE_LOW)
//   sel[N-1:0]          digit selects (polarity per SEL_ACTIVE_LOW)
//   frame_done          one-cycle pulse in the first cycle of each new frame
module seg_scan_ctrl #(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 1024,
  parameter int BLANK_CYCLES   = 4,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   en_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    busy,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   sel,
  output logic                    frame_done
);

  localparam int PCW  = $clog2(SCAN_DIV);
  localparam int IDXW = $clog2(NUM_DIGITS);

  localparam logic [PCW-1:0]  PC_LAST   = PCW'(SCAN_DIV - 1);
  localparam logic [PCW-1:0]  BLANK_END = PCW'(BLANK_CYCLES);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NUM_DIGITS - 1);

  // Inactive levels; XOR-ing an active-high value with these applies polarity.
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;

  logic [PCW-1:0]                  pc;
  logic [IDXW-1:0]                 idx;
  logic [NUM_DIGITS-1:0][3:0]      pend_data;
  logic [NUM_DIGITS-1:0]           pend_en;
  logic [NUM_DIGITS-1:0]           pend_dp;
  logic [NUM_DIGITS-1:0][3:0]      shad_data;
  logic [NUM_DIGITS-1:0]           shad_en;
  logic [NUM_DIGITS-1:0]           shad_dp;

  logic                  tick;
  logic                  wrap;
  logic                  cur_en;
  logic [NUM_DIGITS-1:0] sel_nxt;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign tick   = (pc == PC_LAST);
  assign wrap   = tick && (idx == IDX_LAST);
  assign cur_en = shad_en[idx];

  // Active-high next values for the current slot position; registered below.
  always_comb begin
    sel_nxt = '0;
    if (cur_en && (pc >= BLANK_END)) begin
      sel_nxt[idx] = 1'b1;
    end
    seg_nxt = cur_en ? hex7(shad_data[idx]) : 7'h00;
    dp_nxt  = shad_dp[idx] & cur_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      idx        <= '0;
      pend_data  <= '0;
      pend_en    <= '0;
      pend_dp    <= '0;
      shad_data  <= '0;
      shad_en    <= '0;
      shad_dp    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sel        <= SEL_OFF;
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
    end else begin
      pc <= tick ? '0 : pc + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end

      if (load) begin
        pend_data <= data_in;
        pend_en   <= en_in;
        pend_dp   <= dp_in;
      end

      // The commit reads pending before a same-cycle load overwrites it, so a
      // load landing on the wrap stays pending for the following frame.
      if (wrap && busy) begin
        shad_data <= pend_data;
        shad_en   <= pend_en;
        shad_dp   <= pend_dp;
      end
      busy <= load | (busy & ~wrap);

      frame_done <= wrap;
      sel        <= sel_nxt ^ SEL_OFF;
      seg        <= seg_nxt ^ SEG_OFF;
      dp         <= dp_nxt ^ DP_OFF;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  en;
    logic [3:0]  dpm;
  } frame_t;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  en_in;
  logic [3:0]  dp_in;
  logic        busy;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  sel;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;
  frame_t sb[$];

  logic [6:0] dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg_scan_ctrl #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1),
    .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in),
    .en_in(en_in), .dp_in(dp_in), .busy(busy), .seg(seg), .dp(dp),
    .sel(sel), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] e, input logic [3:0] p);
    data_in = d;
    en_in   = e;
    dp_in   = p;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  task automatic wait_busy_clear(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({tag, ".busy_clear"}, 16'(busy), 16'h0);
    chk({tag, ".fd_at_commit"}, 16'(frame_done), 16'h1);
  endtask

  // Starts on a sample where the scan state is idx=0,pc=0; checks the 16
  // registered outputs belonging to that frame.
  task automatic check_frame(input string tag);
    frame_t e;
    logic [3:0] xs;
    logic [6:0] xg;
    logic       xd;
    int d, p;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 16'h0, 16'h1);
      return;
    end
    e = sb.pop_front();
    for (int j = 0; j < 16; j++) begin
      step();
      d  = j / 4;
      p  = j % 4;
      xs = 4'hF;
      if (e.en[d] && p >= 1) xs[d] = 1'b0;
      xg = e.en[d] ? ~dec[e.d[4*d +: 4]] : 7'h7F;
      xd = ~(e.dpm[d] & e.en[d]);
      chk($sformatf("%s.c%0d.sel", tag, j), 16'(sel), 16'(xs));
      chk($sformatf("%s.c%0d.seg", tag, j), 16'(seg), 16'(xg));
      chk($sformatf("%s.c%0d.dp", tag, j), 16'(dp), 16'(xd));
    end
  endtask

  initial begin
    int n;
    frame_t f;
    rst_n = 1'b1;
    load = 1'b0;
    data_in = '0;
    en_in = '0;
    dp_in = '0;

    // Reset state, applied asynchronously before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    chk("rst.sel", 16'(sel), 16'hF);
    chk("rst.seg", 16'(seg), 16'h7F);
    chk("rst.dp", 16'(dp), 16'h1);
    chk("rst.busy", 16'(busy), 16'h0);
    chk("rst.fd", 16'(frame_done), 16'h0);
    step();
    step();
    rst_n = 1'b1;

    // Basic load/commit/display.
    f = '{16'h3210, 4'hF, 4'b0001};
    sb.push_back(f);
    do_load(16'h3210, 4'hF, 4'b0001);
    chk("t2.busy_set", 16'(busy), 16'h1);
    wait_busy_clear("t2");
    check_frame("t2");
    chk("t2.fd_next", 16'(frame_done), 16'h1);

    // Disabled digits and frame period.
    f = '{16'hFFFF, 4'b0101, 4'b1111};
    sb.push_back(f);
    do_load(16'hFFFF, 4'b0101, 4'b1111);
    wait_busy_clear("t3");
    check_frame("t3");
    for (int r = 0; r < 2; r++) begin
      step();
      chk("t3.fd_width", 16'(frame_done), 16'h0);
      n = 1;
      while (frame_done !== 1'b1 && n < 40) begin
        step();
        n++;
      end
      chk("t3.fd_period", 16'(n), 16'd16);
    end

    // Two loads in one frame: the second replaces the first.
    f = '{16'h1111, 4'hF, 4'h0};
    sb.push_back(f);
    do_load(16'h1111, 4'hF, 4'h0);
    step();
    f = '{16'h2222, 4'hF, 4'h0};
    void'(sb.pop_back());
    sb.push_back(f);
    do_load(16'h2222, 4'hF, 4'h0);
    wait_busy_clear("t4");
    check_frame("t4");

    // Load landing on the wrap tick while older data is pending.
    chk("t5.aligned", 16'(frame_done), 16'h1);
    f = '{16'h4444, 4'hF, 4'h0};
    sb.push_back(f);
    do_load(16'h4444, 4'hF, 4'h0);
    repeat (14) step();
    f = '{16'h5555, 4'hF, 4'hF};
    sb.push_back(f);
    do_load(16'h5555, 4'hF, 4'hF);
    chk("t5.fd", 16'(frame_done), 16'h1);
    chk("t5.busy_held", 16'(busy), 16'h1);
    check_frame("t5a");
    chk("t5.busy_clear", 16'(busy), 16'h0);
    chk("t5.fd2", 16'(frame_done), 16'h1);
    check_frame("t5b");

    // Decode sweep on digit 2.
    for (int v = 0; v < 16; v++) begin
      f = '{16'(v) << 8, 4'b0100, 4'h0};
      sb.push_back(f);
      do_load(16'(v) << 8, 4'b0100, 4'h0);
      wait_busy_clear($sformatf("t6.v%0d", v));
      check_frame($sformatf("t6.v%0d", v));
    end

    // Reset mid-scan with data pending.
    do_load(16'h9876, 4'hF, 4'hF);
    repeat (5) step();
    #3 rst_n = 1'b0;
    #1;
    chk("t1.sel", 16'(sel), 16'hF);
    chk("t1.seg", 16'(seg), 16'h7F);
    chk("t1.dp", 16'(dp), 16'h1);
    chk("t1.busy", 16'(busy), 16'h0);
    chk("t1.fd", 16'(frame_done), 16'h0);
    step();
    rst_n = 1'b1;
    f = '{16'h0000, 4'h0, 4'h0};
    sb.push_back(f);
    check_frame("t1.blank");
    chk("t1.busy_after", 16'(busy), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Parametrised time-multiplexed driver for a common-select seven-segment display bank of NUM_DIGITS digits.
- Takes packed hex nibbles with per-digit enable and decimal-point masks.
- Double-buffers them and commits new values only at frame boundaries, so digits never tear.
- Scans one digit per SCAN_DIV clocks, with a programmable anti-ghosting blank window.
- Successor to the fixed 8-digit scanner; sits between board-level data sources and the display pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..16)
SCAN_DIV, 1024, clocks per digit slot (>= 2)
BLANK_CYCLES, 4, clocks at start of each slot with all selects inactive (0 <= BLANK_CYCLES < SCAN_DIV)
SEL_ACTIVE_LOW, 1, 1 = select lines active-low
SEG_ACTIVE_LOW, 0, 1 = segment and dp lines active-low

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load  in  1  one-cycle strobe; captures data_in/en_in/dp_in into pending buffer
data_in  in  4*NUM_DIGITS  digit i hex value at [4i+3:4i]
en_in  in  NUM_DIGITS  bit i = 1 lights digit i
dp_in  in  NUM_DIGITS  bit i = 1 lights decimal point of digit i
busy  out  1  pending buffer holds uncommitted data
seg  out  7  segments, seg[0]=a .. seg[6]=g
dp  out  1  decimal point
sel  out  NUM_DIGITS  digit select, bit i = digit i
frame_done  out  1  one-cycle pulse per completed scan frame

Behaviour:
- Reset (async, rst_n=0):
  - Prescaler pc=0, index idx=0; pending and shadow data/en/dp = 0; busy=0; frame_done=0.
  - sel all inactive, seg all inactive, dp inactive (levels per polarity parameters).
- Prescaler, every clk:
  - If pc==SCAN_DIV-1: pc<=0 and a tick fires. Otherwise pc<=pc+1.
- Index:
  - On a tick, idx<=idx+1, wrapping NUM_DIGITS-1 -> 0.
  - The tick with idx==NUM_DIGITS-1 is the "wrap tick".
- Output registers (1-cycle latency from pc/idx):
  - sel_int = one-hot(idx) if shadow_en[idx]=1 and pc>=BLANK_CYCLES, else 0.
  - seg_int = hexdecode(shadow_data[idx]) if shadow_en[idx], else 0.
  - dp_int = shadow_dp[idx] & shadow_en[idx].
  - Each output is inverted when its polarity parameter is 1.
- Decode (gfedcba, active-high):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Load/commit:
  - load=1: pending <= inputs; busy<=1 next cycle.
  - On a wrap tick with busy=1: shadow <= pending; busy<=0.
  - Load while busy: pending overwritten, last load wins.
  - Load on the same cycle as a commit: the commit moves the pre-existing pending contents. The new load stays pending and busy stays 1 until the next frame.
  - Load with busy=0 on a wrap tick: not committed this frame.
- frame_done: registered; high for exactly the one cycle after each wrap tick, i.e. the first cycle idx=0.
- Disabled digits: select never asserted for their whole slot; slot time still consumed, so scan rate is fixed.
- No digit is ever selected during blank windows, so two selects are never active in the same cycle.

Test Plan:
(Benches use NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1, SEL_ACTIVE_LOW=1, SEG_ACTIVE_LOW=1.)
1. Reset mid-scan: assert rst_n=0 at an arbitrary cycle -> sel=4'b1111, seg=7'h7F, dp=1, busy=0, frame_done=0 immediately, without waiting for a clk edge.
2. Load data_in=16'h3210, en_in=4'hF, dp_in=4'b0001 after reset:
   - busy=1 until the first wrap tick, then 0.
   - Next frame, digit 0: sel=4'b1110, seg=7'h40, dp=0.
   - Digit 3: sel=4'b0111, seg=7'h30, dp=1.
   - Each select is active for 3 of every 4 cycles.
3. en_in=4'b0101, data_in=16'hFFFF -> digits 1 and 3 never selected. frame_done pulses every 16 cycles exactly.
4. Two loads, h1111 then h2222, within one frame -> only h2222 ever displayed; h1111 never appears on seg.
5. Load h5555 on the same cycle as a wrap tick while h4444 is pending:
   - h4444 is displayed the next frame, with busy still 1.
   - h5555 is displayed the frame after.
6. Sweep data values 0..F on digit 2 -> seg matches the decode table inverted: 0 -> 7'h40, b -> 7'h03, F -> 7'h0E.
